saw_receiver: RTL

- Receive side of the stop-and-wait ARQ link; consumes the CRC-protected frames the SAW transmitter produces.
- Checks each frame's CRC serially and filters duplicates with a 1-bit sequence number.
- Delivers new payloads to a downstream sink over valid/ready.
- Returns ACK pulses (and NAK pulses when the optional feature is compiled in) to the transmitter's control FSM.

---
 rtl/saw_pkg.sv | 34 +++
 rtl/saw_receiver_if.sv | 39 +++
 rtl/crc_serial_chk.sv | 36 +++
 rtl/saw_receiver.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/saw_pkg.sv
// saw_pkg -- definitions shared by the stop-and-wait ARQ link (transmitter
// CRC generator and receiver).
//   state_t       : receiver FSM state encoding
//   dbg_t         : receiver debug view (FSM state + expected sequence bit)
//   SAW_*         : default frame geometry and field positions
//   DEFAULT_POLY  : CRC generator x^3+x+1, low CW bits (leading 1 implicit)
package saw_pkg;

    localparam int SAW_BW  = 10;  // total frame width
    localparam int SAW_CW  = 3;   // CRC width
    localparam int SAW_ECW = 8;   // CRC error counter width

    // Frame layout: [SEQ_BIT] seq, [SEQ_BIT-1:CRC_MSB+1] payload, [CRC_MSB:CRC_LSB] CRC
    localparam int SEQ_BIT = SAW_BW - 1;
    localparam int CRC_MSB = SAW_CW - 1;
    localparam int CRC_LSB = 0;

    localparam logic [SAW_CW-1:0] DEFAULT_POLY = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_DECIDE  = 3'd2,
        ST_DELIVER = 3'd3,
        ST_ACK     = 3'd4,
        ST_NAK     = 3'd5
    } state_t;

    typedef struct packed {
        state_t state;
        logic   expected_seq;
    } dbg_t;

endpackage

// File: rtl/saw_receiver_if.sv
// saw_receiver_if -- signal bundle between the SAW receiver and its
// environment (frame source, payload sink, transmitter control FSM).
//   master : drives rx_valid/rx_frame/out_ready, observes everything else
//   slave  : the receiver itself
//
// Handshake rule for both rx_* and out_* channels: a transfer happens on a
// rising clk edge where valid and ready are both high; the source holds
// data stable while valid is high and ready is low, and ready never depends
// combinationally on valid.
interface saw_receiver_if
    import saw_pkg::*;
#(
    parameter int BW  = SAW_BW,
    parameter int CW  = SAW_CW,
    parameter int ECW = SAW_ECW
) ();

    logic              rx_valid;
    logic [BW-1:0]     rx_frame;
    logic              rx_ready;
    logic              out_valid;
    logic [BW-CW-2:0]  out_data;
    logic              out_ready;
    logic              ack_valid;
    logic              ack_seq;
    logic              nak_valid;
    logic [ECW-1:0]    err_cnt;

    modport master (
        output rx_valid, rx_frame, out_ready,
        input  rx_ready, out_valid, out_data, ack_valid, ack_seq, nak_valid, err_cnt
    );

    modport slave (
        input  rx_valid, rx_frame, out_ready,
        output rx_ready, out_valid, out_data, ack_valid, ack_seq, nak_valid, err_cnt
    );

endinterface

// File: rtl/crc_serial_chk.sv
// crc_serial_chk -- serial CW-bit LFSR divider. Feeding a whole frame MSB
// first leaves frame(x) mod G(x) in remainder; zero means the CRC checks.
//   clk, rst  : clock, synchronous active-high reset
//   clear     : zero the remainder (start of a new frame)
//   shift_en  : shift bit_in into the divider this cycle
//   bit_in    : next frame bit, MSB first
//   remainder : current remainder
module crc_serial_chk
    import saw_pkg::*;
#(
    parameter int            CW   = SAW_CW,
    parameter logic [CW-1:0] POLY = DEFAULT_POLY
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          shift_en,
    input  logic          bit_in,
    output logic [CW-1:0] remainder
);

    logic [CW-1:0] rem_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rem_q <= '0;
        end else if (shift_en) begin
            // Shift in the new bit; when the bit falling off the top is 1
            // subtract (xor) the generator.
            rem_q <= {rem_q[CW-2:0], bit_in} ^ (rem_q[CW-1] ? POLY : '0);
        end
    end

    assign remainder = rem_q;

endmodule

// File: rtl/saw_receiver.sv
// saw_receiver -- receive side of the stop-and-wait ARQ link.
// Checks each frame's CRC serially, drops duplicates using a 1-bit sequence
// number, delivers new payloads to the sink and returns ACK pulses (plus NAK
// pulses on CRC failure when SAW_RX_NAK_EN is defined).
//
// Build option: `define SAW_RX_NAK_EN to include the NAK state; otherwise a
// CRC failure returns to IDLE silently and nak_valid is constant 0.
//
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous reset, active-high
//   bus  : saw_receiver_if.slave (rx_valid/rx_frame/rx_ready,
//          out_valid/out_data/out_ready, ack_valid/ack_seq/nak_valid, err_cnt)
//   dbg  : FSM state and expected sequence bit for observation
module saw_receiver
    import saw_pkg::*;
#(
    parameter int            BW   = SAW_BW,
    parameter int            CW   = SAW_CW,
    parameter logic [CW-1:0] POLY = DEFAULT_POLY,
    parameter int            ECW  = SAW_ECW
) (
    input  logic          clk,
    input  logic          rst,
    saw_receiver_if.slave bus,
    output dbg_t          dbg
);

    localparam int CNTW = $clog2(BW);
    localparam int PW   = BW - CW - 1;

    state_t          state_q, state_next;
    logic [BW-1:0]   frame_q;
    logic [CNTW-1:0] bit_cnt_q;
    logic            exp_seq_q;
    logic [ECW-1:0]  err_cnt_q;
    logic            rx_ready_q;
    logic            out_valid_q;
    logic [PW-1:0]   out_data_q;
    logic            ack_valid_q;
    logic            ack_seq_q;
    logic            nak_valid_q;

    logic            crc_clear;
    logic            crc_shift;
    logic [CW-1:0]   rem;
    logic            accept;
    logic            crc_ok;
    logic            is_new;

    assign accept = bus.rx_valid && rx_ready_q;
    assign crc_ok = (rem == '0);
    assign is_new = (frame_q[BW-1] == exp_seq_q);

    crc_serial_chk #(.CW(CW), .POLY(POLY)) u_crc (
        .clk       (clk),
        .rst       (rst),
        .clear     (crc_clear),
        .shift_en  (crc_shift),
        .bit_in    (frame_q[BW-1]),
        .remainder (rem)
    );

    always_comb begin
        state_next = state_q;
        crc_clear  = 1'b0;
        crc_shift  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    crc_clear  = 1'b1;
                    state_next = ST_CHECK;
                end
            end
            ST_CHECK: begin
                crc_shift = 1'b1;
                if (bit_cnt_q == CNTW'(BW - 1)) begin
                    state_next = ST_DECIDE;
                end
            end
            ST_DECIDE: begin
                if (crc_ok) begin
                    state_next = is_new ? ST_DELIVER : ST_ACK;
                end else begin
`ifdef SAW_RX_NAK_EN
                    state_next = ST_NAK;
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_DELIVER: begin
                if (out_valid_q && bus.out_ready) begin
                    state_next = ST_ACK;
                end
            end
            ST_ACK:  state_next = ST_IDLE;
            ST_NAK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            exp_seq_q   <= 1'b0;
            err_cnt_q   <= '0;
            rx_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            ack_valid_q <= 1'b0;
            ack_seq_q   <= 1'b0;
            nak_valid_q <= 1'b0;
        end else begin
            state_q <= state_next;

            // Strobes are decoded from the next state so they line up with
            // the state they belong to while still coming from flops.
            rx_ready_q  <= (state_next == ST_IDLE);
            out_valid_q <= (state_next == ST_DELIVER);
            ack_valid_q <= (state_next == ST_ACK);
`ifdef SAW_RX_NAK_EN
            nak_valid_q <= (state_next == ST_NAK);
`else
            nak_valid_q <= 1'b0;
`endif
            if (state_next == ST_ACK || state_next == ST_NAK) begin
                ack_seq_q <= frame_q[BW-1];
            end

            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        frame_q   <= bus.rx_frame;
                        bit_cnt_q <= '0;
                    end
                end
                ST_CHECK: begin
                    // Rotate rather than shift: after BW cycles the frame
                    // is back in place for field extraction in DECIDE.
                    frame_q   <= {frame_q[BW-2:0], frame_q[BW-1]};
                    bit_cnt_q <= bit_cnt_q + 1'b1;
                end
                ST_DECIDE: begin
                    if (crc_ok && is_new) begin
                        out_data_q <= frame_q[BW-2:CW];
                    end
                    if (!crc_ok && (err_cnt_q != '1)) begin
                        err_cnt_q <= err_cnt_q + 1'b1;
                    end
                end
                ST_DELIVER: begin
                    if (out_valid_q && bus.out_ready) begin
                        exp_seq_q <= ~exp_seq_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.rx_ready  = rx_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.ack_valid = ack_valid_q;
    assign bus.ack_seq   = ack_seq_q;
    assign bus.nak_valid = nak_valid_q;
    assign bus.err_cnt   = err_cnt_q;

    assign dbg = '{state: state_q, expected_seq: exp_seq_q};

endmodule
